// File: rtl/bitmap_line_packer_pkg.sv
// rtl/bitmap_line_packer_pkg.sv - shared defaults, address-width helper and state encoding
package bitmap_line_packer_pkg;

    localparam int IN_WIDTH_DEF   = 32;
    localparam int MEM_WIDTH_DEF  = 128;
    localparam int MEM_DEPTH_DEF  = 2048;
    localparam int WORDS_PER_LINE = MEM_WIDTH_DEF / IN_WIDTH_DEF;

    function automatic int addr_width_f(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) w++;
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bitmap_line_packer.sv
// rtl/bitmap_line_packer.sv - packs host bitmap words MSB-first into memory lines
// Words shift in from the LSB end, so the first word of a line lands in the top bits.
module bitmap_line_packer
    import bitmap_line_packer_pkg::*;
#(
    parameter int IN_WIDTH   = IN_WIDTH_DEF,
    parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int ADDR_WIDTH = addr_width_f(MEM_DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  init,
    input  logic [IN_WIDTH-1:0]   in_bitmap,
    input  logic                  in_bitmap_valid,
    input  logic                  flush,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [MEM_WIDTH-1:0]  mem_wr_data,
    output logic [ADDR_WIDTH:0]   line_count,
    output logic                  overflow,
    output logic                  flush_done,
    output logic                  loading
);

    localparam int N     = MEM_WIDTH / IN_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [MEM_WIDTH-1:0]  shift_q, shift_d;
    logic [ADDR_WIDTH:0]   line_count_q, line_count_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [MEM_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                  flush_done_q, flush_done_d;
    logic                  loading_q, loading_d;

    logic [MEM_WIDTH-1:0]  line_v;
    logic [MEM_WIDTH-1:0]  write_data;
    logic [IDX_W-1:0]      idx_v;
    logic                  write_due;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        line_count_d = line_count_q;
        overflow_d   = overflow_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        flush_done_d = 1'b0;
        loading_d    = loading_q;
        line_v       = shift_q;
        idx_v        = idx_q;
        write_due    = 1'b0;
        write_data   = '0;

        if (init) begin
            state_d      = LOAD;
            loading_d    = 1'b1;
            idx_d        = '0;
            shift_d      = '0;
            line_count_d = '0;
            overflow_d   = 1'b0;
        end else if (state_q == LOAD) begin
            if (in_bitmap_valid) begin
                line_v = {shift_q[MEM_WIDTH-IN_WIDTH-1:0], in_bitmap};
                idx_v  = idx_q + 1'b1;
                if (idx_q == IDX_W'(N - 1)) begin
                    write_due  = 1'b1;
                    write_data = line_v;
                    idx_v      = '0;
                    line_v     = '0;
                end
            end
            idx_d   = idx_v;
            shift_d = line_v;

            // A word completing a line on the flush edge already wrote it, so no pad write.
            if (flush && !write_due && idx_v != '0) begin
                write_due  = 1'b1;
                write_data = line_v << ((N - int'(idx_v)) * IN_WIDTH);
            end

            if (write_due) begin
                if (line_count_q == (ADDR_WIDTH + 1)'(MEM_DEPTH)) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en_d      = 1'b1;
                    wr_addr_d    = line_count_q[ADDR_WIDTH-1:0];
                    wr_data_d    = write_data;
                    line_count_d = line_count_q + 1'b1;
                end
            end

            if (flush) begin
                state_d      = DONE;
                loading_d    = 1'b0;
                flush_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            shift_q      <= '0;
            line_count_q <= '0;
            overflow_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            flush_done_q <= 1'b0;
            loading_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            line_count_q <= line_count_d;
            overflow_q   <= overflow_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            flush_done_q <= flush_done_d;
            loading_q    <= loading_d;
        end
    end

    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign line_count  = line_count_q;
    assign overflow    = overflow_q;
    assign flush_done  = flush_done_q;
    assign loading     = loading_q;

endmodule

// File: tb/tb_bitmap_line_packer.sv
// tb/tb_bitmap_line_packer.sv - directed self-checking bench for bitmap_line_packer
module tb_bitmap_line_packer;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         init = 1'b0;
    logic [31:0]  in_bitmap = '0;
    logic         in_bitmap_valid = 1'b0;
    logic         flush = 1'b0;

    logic         mem_wr_en;
    logic [10:0]  mem_wr_addr;
    logic [127:0] mem_wr_data;
    logic [11:0]  line_count;
    logic         overflow;
    logic         flush_done;
    logic         loading;

    logic         s_wr_en;
    logic [1:0]   s_wr_addr;
    logic [127:0] s_wr_data;
    logic [2:0]   s_line_count;
    logic         s_overflow;
    logic         s_flush_done;
    logic         s_loading;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int fd_cyc = -1;
    int flush_cyc;

    logic [10:0]  wa[$];
    logic [127:0] wd[$];
    logic         wf[$];
    logic [1:0]   sa[$];

    bitmap_line_packer dut (
        .clock(clock), .reset(reset), .init(init), .in_bitmap(in_bitmap),
        .in_bitmap_valid(in_bitmap_valid), .flush(flush),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .line_count(line_count), .overflow(overflow), .flush_done(flush_done),
        .loading(loading)
    );

    bitmap_line_packer #(.MEM_DEPTH(4), .ADDR_WIDTH(2)) dut_small (
        .clock(clock), .reset(reset), .init(init), .in_bitmap(in_bitmap),
        .in_bitmap_valid(in_bitmap_valid), .flush(flush),
        .mem_wr_en(s_wr_en), .mem_wr_addr(s_wr_addr), .mem_wr_data(s_wr_data),
        .line_count(s_line_count), .overflow(s_overflow), .flush_done(s_flush_done),
        .loading(s_loading)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mem_wr_en) begin
            wa.push_back(mem_wr_addr);
            wd.push_back(mem_wr_data);
            wf.push_back(flush_done);
        end
        if (flush_done) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
        end
        if (s_wr_en) sa.push_back(s_wr_addr);
    end

    task automatic clear_log();
        @(negedge clock);
        wa.delete(); wd.delete(); wf.delete(); sa.delete();
        fd_cnt = 0;
        fd_cyc = -1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic f, input logic i);
        in_bitmap_valid = v;
        in_bitmap = w;
        flush = f;
        init = i;
        @(posedge clock);
        #1;
        in_bitmap_valid = 1'b0;
        flush = 1'b0;
        init = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        @(negedge clock);
        total++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data, line_count, overflow, flush_done, loading} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got en=%b addr=%h data=%h lc=%0d ovf=%b fd=%b ld=%b want all 0",
                     mem_wr_en, mem_wr_addr, mem_wr_data, line_count, overflow, flush_done, loading);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_idle_done();
        clear_log();
        for (int k = 0; k < 4; k++) drive(1'b1, 32'h1234_0000 + k, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        idle(2);
        total++;
        if (wa.size() !== 0 || fd_cnt !== 0) begin
            bad++;
            $display("FAIL idle_ignored got writes=%0d fd=%0d want 0 0", wa.size(), fd_cnt);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        idle(1);
        clear_log();
        for (int k = 0; k < 4; k++) drive(1'b1, 32'h5678_0000 + k, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        idle(2);
        total++;
        if (wa.size() !== 0 || fd_cnt !== 0 || loading !== 1'b0) begin
            bad++;
            $display("FAIL done_ignored got writes=%0d fd=%0d ld=%b want 0 0 0", wa.size(), fd_cnt, loading);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        idle(2);
        total++;
        if (loading !== 1'b1 || fd_cnt !== 0) begin
            bad++;
            $display("FAIL init_beats_flush got ld=%b fd=%0d want 1 0", loading, fd_cnt);
        end
    endtask

    task automatic test_full_lines();
        logic [31:0] words [16];
        words = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff,
                  32'hbfffffff, 32'hffffffff, 32'hffffffff, 32'hfffffffe,
                  32'hdfffffff, 32'hffffffff, 32'hffffffff, 32'hfffffffb,
                  32'hefffffff, 32'hffffffff, 32'hffffffff, 32'hfffffffb};
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        clear_log();
        for (int k = 0; k < 16; k++) drive(1'b1, words[k], 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        flush_cyc = cyc;
        idle(3);
        total++;
        if (wa.size() !== 4) begin
            bad++;
            $display("FAIL full_write_count got %0d want 4", wa.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (wa[k] !== 11'(k)) begin
                    bad++;
                    $display("FAIL full_addr%0d got %0d want %0d", k, wa[k], k);
                end
            end
            total++;
            if (wd[1] !== 128'hbfffffff_ffffffff_ffffffff_fffffffe) begin
                bad++;
                $display("FAIL full_data1 got %h want bfffffffffffffffffffffff fffffffe", wd[1]);
            end
            total++;
            if (wd[3] !== 128'hefffffff_ffffffff_ffffffff_fffffffb) begin
                bad++;
                $display("FAIL full_data3 got %h want efffffffffffffffffffffff fffffffb", wd[3]);
            end
        end
        total++;
        if (fd_cnt !== 1 || fd_cyc !== flush_cyc) begin
            bad++;
            $display("FAIL full_flush_done got cnt=%0d cyc=%0d want 1 cyc=%0d", fd_cnt, fd_cyc, flush_cyc);
        end
        total++;
        if (line_count !== 12'd4) begin
            bad++;
            $display("FAIL full_line_count got %0d want 4", line_count);
        end
    endtask

    task automatic test_partial();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        clear_log();
        for (int k = 1; k <= 5; k++) drive(1'b1, 32'(k), 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        idle(3);
        total++;
        if (wa.size() !== 2) begin
            bad++;
            $display("FAIL partial_write_count got %0d want 2", wa.size());
        end else begin
            total++;
            if (wd[0] !== 128'h00000001_00000002_00000003_00000004 || wa[0] !== 11'd0 || wf[0] !== 1'b0) begin
                bad++;
                $display("FAIL partial_line0 got addr=%0d data=%h fd=%b want 0 00000001000000020000000300000004 0",
                         wa[0], wd[0], wf[0]);
            end
            total++;
            if (wd[1] !== 128'h00000005_00000000_00000000_00000000 || wa[1] !== 11'd1 || wf[1] !== 1'b1) begin
                bad++;
                $display("FAIL partial_line1 got addr=%0d data=%h fd=%b want 1 00000005000000000000000000000000 1",
                         wa[1], wd[1], wf[1]);
            end
        end
        total++;
        if (line_count !== 12'd2 || fd_cnt !== 1) begin
            bad++;
            $display("FAIL partial_count got lc=%0d fd=%0d want 2 1", line_count, fd_cnt);
        end
    endtask

    task automatic test_flush_with_last();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        clear_log();
        drive(1'b1, 32'h11111111, 1'b0, 1'b0);
        drive(1'b1, 32'h22222222, 1'b0, 1'b0);
        drive(1'b1, 32'h33333333, 1'b0, 1'b0);
        drive(1'b1, 32'haaaaaaaa, 1'b1, 1'b0);
        idle(3);
        total++;
        if (wa.size() !== 1) begin
            bad++;
            $display("FAIL flushlast_write_count got %0d want 1", wa.size());
        end else begin
            total++;
            if (wa[0] !== 11'd0 || wd[0] !== 128'h11111111_22222222_33333333_aaaaaaaa || wf[0] !== 1'b1) begin
                bad++;
                $display("FAIL flushlast_line got addr=%0d data=%h fd=%b want 0 11111111222222223333333 3aaaaaaaa 1",
                         wa[0], wd[0], wf[0]);
            end
        end
        total++;
        if (line_count !== 12'd1 || fd_cnt !== 1) begin
            bad++;
            $display("FAIL flushlast_count got lc=%0d fd=%0d want 1 1", line_count, fd_cnt);
        end
    endtask

    task automatic test_overflow();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        clear_log();
        for (int k = 0; k < 20; k++) drive(1'b1, 32'hc000_0000 + k, 1'b0, 1'b0);
        idle(3);
        total++;
        if (sa.size() !== 4) begin
            bad++;
            $display("FAIL ovf_write_count got %0d want 4", sa.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (sa[k] !== 2'(k)) begin
                    bad++;
                    $display("FAIL ovf_addr%0d got %0d want %0d", k, sa[k], k);
                end
            end
        end
        total++;
        if (s_overflow !== 1'b1 || s_line_count !== 3'd4) begin
            bad++;
            $display("FAIL ovf_state got ovf=%b lc=%0d want 1 4", s_overflow, s_line_count);
        end
        total++;
        if (overflow !== 1'b0 || line_count !== 12'd5) begin
            bad++;
            $display("FAIL ovf_big_dut got ovf=%b lc=%0d want 0 5", overflow, line_count);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        idle(1);
        total++;
        if (s_overflow !== 1'b0 || s_line_count !== 3'd0) begin
            bad++;
            $display("FAIL ovf_cleared got ovf=%b lc=%0d want 0 0", s_overflow, s_line_count);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        clear_log();
        drive(1'b1, 32'h01010101, 1'b0, 1'b0);
        drive(1'b1, 32'h02020202, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        total++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data, line_count, overflow, flush_done, loading} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got en=%b lc=%0d ld=%b want all 0", mem_wr_en, line_count, loading);
        end
        idle(2);
        reset = 1'b0;
        idle(1);
        for (int k = 0; k < 4; k++) drive(1'b1, 32'h0f0f0000 + k, 1'b0, 1'b0);
        idle(2);
        total++;
        if (wa.size() !== 0 || loading !== 1'b0) begin
            bad++;
            $display("FAIL midreset_ignored got writes=%0d ld=%b want 0 0", wa.size(), loading);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) drive(1'b1, 32'ha0000000 + k, 1'b0, 1'b0);
        idle(3);
        total++;
        if (wa.size() !== 1) begin
            bad++;
            $display("FAIL midreset_write_count got %0d want 1", wa.size());
        end else begin
            total++;
            if (wa[0] !== 11'd0 || wd[0] !== 128'ha0000000_a0000001_a0000002_a0000003) begin
                bad++;
                $display("FAIL midreset_line got addr=%0d data=%h want 0 a0000000a0000001a0000002a0000003",
                         wa[0], wd[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_done();
        test_full_lines();
        test_partial();
        test_flush_with_last();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
